// File: rtl/his_readout_peak.sv
// Histogram readout with per-pixel peak detection.
// Once an acquisition completes, every bin of every pixel is read from the histogram RAM
// and streamed out over a valid/ready interface. Each accepted bin can be cleared in the
// RAM behind it. At the end of each pixel the highest bin is reported, so that the
// coarse/fine window logic can pick its next window.
module his_readout_peak #(
  parameter int unsigned NB       = 4,
  parameter int unsigned PIXELS   = 200,
  parameter int unsigned PW       = 8,
  parameter int unsigned CW       = 8,
  parameter int unsigned CLEAR_EN = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             his_sel,
  output logic             busy,
  output logic             rd_en,
  output logic [PW+NB-1:0] rd_addr,
  input  logic [CW-1:0]    rd_data,
  output logic             clr_en,
  output logic [PW+NB-1:0] clr_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_data,
  output logic [NB-1:0]    out_bin,
  output logic [PW-1:0]    out_pixel,
  output logic             out_last,
  output logic             peak_valid,
  output logic [NB-1:0]    peak_bin,
  output logic [CW-1:0]    peak_count,
  output logic [PW-1:0]    peak_pixel,
  output logic             peak_sel,
  output logic             done
);

  localparam logic [NB-1:0] LastBin   = NB'((2 ** NB) - 1);
  localparam logic [PW-1:0] LastPixel = PW'(PIXELS - 1);
  localparam bit            ClearEn   = (CLEAR_EN != 0);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRd   = 3'd1;
  localparam logic [2:0] StCap  = 3'd2;
  localparam logic [2:0] StSend = 3'd3;
  localparam logic [2:0] StPeak = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pixel_q, pixel_d;
  logic [NB-1:0] bin_q, bin_d;
  logic [CW-1:0] max_q, max_d;
  logic [NB-1:0] maxbin_q, maxbin_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] out_data_q, out_data_d;
  logic [NB-1:0] out_bin_q, out_bin_d;
  logic [PW-1:0] out_pixel_q, out_pixel_d;
  logic          out_last_q, out_last_d;

  logic last_bin;
  logic last_pixel;
  logic accept;

  assign last_bin   = (bin_q == LastBin);
  assign last_pixel = (pixel_q == LastPixel);
  assign accept     = (state_q == StSend) && out_ready;

  // Scan sequencing, beat capture and running maximum.
  always_comb begin
    state_d     = state_q;
    pixel_d     = pixel_q;
    bin_d       = bin_q;
    max_d       = max_q;
    maxbin_d    = maxbin_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_bin_d   = out_bin_q;
    out_pixel_d = out_pixel_q;
    out_last_d  = out_last_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          sel_d    = his_sel;
          pixel_d  = '0;
          bin_d    = '0;
          max_d    = '0;
          maxbin_d = '0;
          state_d  = StRd;
        end
      end
      StRd: begin
        state_d = StCap;
      end
      StCap: begin
        // RAM returns data one cycle after the read strobe.
        out_data_d  = rd_data;
        out_bin_d   = bin_q;
        out_pixel_d = pixel_q;
        out_last_d  = last_bin && last_pixel;
        state_d     = StSend;
      end
      StSend: begin
        if (out_ready) begin
          // Strictly greater keeps the lowest bin on ties.
          if (out_data_q > max_q) begin
            max_d    = out_data_q;
            maxbin_d = bin_q;
          end
          if (!last_bin) begin
            bin_d   = bin_q + NB'(1);
            state_d = StRd;
          end else begin
            state_d = StPeak;
          end
        end
      end
      StPeak: begin
        max_d    = '0;
        maxbin_d = '0;
        bin_d    = '0;
        if (!last_pixel) begin
          pixel_d = pixel_q + PW'(1);
          state_d = StRd;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset abandons any scan in progress.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= StIdle;
      pixel_q     <= '0;
      bin_q       <= '0;
      max_q       <= '0;
      maxbin_q    <= '0;
      sel_q       <= 1'b0;
      out_data_q  <= '0;
      out_bin_q   <= '0;
      out_pixel_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixel_q     <= pixel_d;
      bin_q       <= bin_d;
      max_q       <= max_d;
      maxbin_q    <= maxbin_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_bin_q   <= out_bin_d;
      out_pixel_q <= out_pixel_d;
      out_last_q  <= out_last_d;
    end
  end

  // Strobes and addresses decoded from the current state; addresses idle at zero.
  always_comb begin
    busy       = (state_q != StIdle) && (state_q != StDone);
    rd_en      = (state_q == StRd);
    rd_addr    = rd_en ? {pixel_q, bin_q} : '0;
    clr_en     = ClearEn && accept;
    clr_addr   = clr_en ? {pixel_q, bin_q} : '0;
    out_valid  = (state_q == StSend);
    out_data   = out_data_q;
    out_bin    = out_bin_q;
    out_pixel  = out_pixel_q;
    out_last   = out_last_q;
    peak_valid = (state_q == StPeak);
    peak_bin   = maxbin_q;
    peak_count = max_q;
    peak_pixel = pixel_q;
    peak_sel   = sel_q;
    done       = (state_q == StDone);
  end

endmodule

// File: tb/tb_his_readout_peak.sv
// Directed bench for his_readout_peak: two instances (clearing and read-only) with RAM models.
module tb_his_readout_peak;

  localparam int unsigned NB    = 2;
  localparam int unsigned PIX   = 2;
  localparam int unsigned PW    = 1;
  localparam int unsigned CW    = 8;
  localparam int unsigned AW    = PW + NB;
  localparam int unsigned WORDS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic res;
  int   errors = 0;
  int   checks = 0;

  // Instance A (clearing)
  logic          start_a, sel_a, busy_a, rd_en_a, clr_en_a, out_valid_a, out_ready_a;
  logic [AW-1:0] rd_addr_a, clr_addr_a;
  logic [CW-1:0] rd_data_a, out_data_a, peak_count_a;
  logic [NB-1:0] out_bin_a, peak_bin_a;
  logic [PW-1:0] out_pixel_a, peak_pixel_a;
  logic          out_last_a, peak_valid_a, peak_sel_a, done_a;
  // Instance B (read-only)
  logic          start_b, sel_b, busy_b, rd_en_b, clr_en_b, out_valid_b, out_ready_b;
  logic [AW-1:0] rd_addr_b, clr_addr_b;
  logic [CW-1:0] rd_data_b, out_data_b, peak_count_b;
  logic [NB-1:0] out_bin_b, peak_bin_b;
  logic [PW-1:0] out_pixel_b, peak_pixel_b;
  logic          out_last_b, peak_valid_b, peak_sel_b, done_b;

  his_readout_peak #(.NB(NB), .PIXELS(PIX), .PW(PW), .CW(CW), .CLEAR_EN(1)) u_dut (
    .clk(clk), .res(res), .start(start_a), .his_sel(sel_a), .busy(busy_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .clr_en(clr_en_a), .clr_addr(clr_addr_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_bin(out_bin_a), .out_pixel(out_pixel_a), .out_last(out_last_a),
    .peak_valid(peak_valid_a), .peak_bin(peak_bin_a), .peak_count(peak_count_a),
    .peak_pixel(peak_pixel_a), .peak_sel(peak_sel_a), .done(done_a)
  );

  his_readout_peak #(.NB(NB), .PIXELS(PIX), .PW(PW), .CW(CW), .CLEAR_EN(0)) u_dut_nc (
    .clk(clk), .res(res), .start(start_b), .his_sel(sel_b), .busy(busy_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .clr_en(clr_en_b), .clr_addr(clr_addr_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_bin(out_bin_b), .out_pixel(out_pixel_b), .out_last(out_last_b),
    .peak_valid(peak_valid_b), .peak_bin(peak_bin_b), .peak_count(peak_count_b),
    .peak_pixel(peak_pixel_b), .peak_sel(peak_sel_b), .done(done_b)
  );

  // RAM models: synchronous read, clear-write, bench load port
  logic [CW-1:0] ram_a [WORDS];
  logic [CW-1:0] ram_b [WORDS];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [CW-1:0] load_val;

  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= ram_a[rd_addr_a];
    if (clr_en_a) ram_a[clr_addr_a] <= '0;
    if (rd_en_b) rd_data_b <= ram_b[rd_addr_b];
    if (clr_en_b) ram_b[clr_addr_b] <= '0;
    if (load_en) begin
      ram_a[load_addr] <= load_val;
      ram_b[load_addr] <= load_val;
    end
  end

  // Monitors, sampled on the falling edge
  logic [CW-1:0] bd_a [$];
  logic [NB-1:0] bb_a [$];
  logic [PW-1:0] bp_a [$];
  logic          bl_a [$];
  logic [NB-1:0] pk_bin_a [$];
  logic [CW-1:0] pk_cnt_a [$];
  logic [PW-1:0] pk_pix_a [$];
  logic          pk_sel_a [$];
  logic [CW-1:0] bd_b [$];
  logic          bl_b [$];
  logic [CW-1:0] pk_cnt_b [$];
  int            rd_cnt_a = 0, clr_cnt_a = 0, done_cnt_a = 0, unstable_a = 0;
  int            clr_cnt_b = 0, done_cnt_b = 0;
  logic          hold_a = 1'b0;
  logic [CW+NB+PW:0] hold_v_a = '0;

  always @(negedge clk) begin
    if (rd_en_a) rd_cnt_a <= rd_cnt_a + 1;
    if (clr_en_a) clr_cnt_a <= clr_cnt_a + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (out_valid_a && out_ready_a) begin
      bd_a.push_back(out_data_a);
      bb_a.push_back(out_bin_a);
      bp_a.push_back(out_pixel_a);
      bl_a.push_back(out_last_a);
    end
    if (peak_valid_a) begin
      pk_bin_a.push_back(peak_bin_a);
      pk_cnt_a.push_back(peak_count_a);
      pk_pix_a.push_back(peak_pixel_a);
      pk_sel_a.push_back(peak_sel_a);
    end
    if (hold_a && out_valid_a &&
        ({out_data_a, out_bin_a, out_pixel_a, out_last_a} !== hold_v_a))
      unstable_a <= unstable_a + 1;
    hold_a   <= out_valid_a && !out_ready_a;
    hold_v_a <= {out_data_a, out_bin_a, out_pixel_a, out_last_a};
  end

  always @(negedge clk) begin
    if (clr_en_b) clr_cnt_b <= clr_cnt_b + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (out_valid_b && out_ready_b) begin
      bd_b.push_back(out_data_b);
      bl_b.push_back(out_last_b);
    end
    if (peak_valid_b) pk_cnt_b.push_back(peak_count_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7);
    return {w7, w6, w5, w4, w3, w2, w1, w0};
  endfunction

  // Entered and left at #1 after a rising edge
  task automatic load_ram(input logic [63:0] words);
    for (int i = 0; i < WORDS; i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_val  = words[i*8 +: 8];
      @(posedge clk); #1;
    end
    load_en = 1'b0;
  endtask

  // mode 0: ready high; mode 1: ready 1,0,0,1 repeating; mode 2: extra start pulses mid-scan
  task automatic scan_a(input logic sel, input int mode, output int dcyc);
    int n;
    sel_a = sel; start_a = 1'b1; out_ready_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (done_a !== 1'b1 && n < 400) begin
      if (mode == 1) out_ready_a = (n % 4 == 0) || (n % 4 == 3);
      if (mode == 2) start_a = (n == 5) || (n == 12);
      @(posedge clk); #1;
      n++;
    end
    start_a = 1'b0; out_ready_a = 1'b1;
    dcyc = n + 1;  // done occupies this cycle, counting cycles after the start edge
    check("done_seen", done_a, 1);
    check("busy_low_with_done", busy_a, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_beats_a(input string tag, input int base, input logic [63:0] words);
    check({tag, "_beats"}, bd_a.size(), base + 8);
    if (bd_a.size() == base + 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("%s_data%0d", tag, i), bd_a[base+i], words[i*8 +: 8]);
        check($sformatf("%s_bin%0d", tag, i), bb_a[base+i], i % 4);
        check($sformatf("%s_pix%0d", tag, i), bp_a[base+i], i / 4);
        check($sformatf("%s_last%0d", tag, i), bl_a[base+i], (i == 7) ? 1 : 0);
      end
    end
  endtask

  task automatic check_peaks_a(input string tag, input int base, input int b0, input int c0,
                               input int b1, input int c1, input logic sel);
    check({tag, "_peaks"}, pk_cnt_a.size(), base + 2);
    if (pk_cnt_a.size() == base + 2) begin
      check({tag, "_p0bin"}, pk_bin_a[base], b0);
      check({tag, "_p0cnt"}, pk_cnt_a[base], c0);
      check({tag, "_p0pix"}, pk_pix_a[base], 0);
      check({tag, "_p0sel"}, pk_sel_a[base], sel);
      check({tag, "_p1bin"}, pk_bin_a[base+1], b1);
      check({tag, "_p1cnt"}, pk_cnt_a[base+1], c1);
      check({tag, "_p1pix"}, pk_pix_a[base+1], 1);
      check({tag, "_p1sel"}, pk_sel_a[base+1], sel);
    end
  endtask

  initial begin
    logic [63:0] s1w, s3w, s4w, s5w;
    int dcyc, base, pbase, cbase, dbase, rsnap, csnap, idx, n;

    s1w = pack(3, 7, 7, 1, 0, 0, 0, 0);
    s3w = pack(255, 0, 0, 255, 0, 0, 0, 0);
    s4w = pack(1, 2, 3, 4, 4, 3, 2, 1);
    s5w = pack(3, 7, 7, 1, 5, 6, 8, 9);

    res = 1'b0; start_a = 1'b1; sel_a = 1'b1; out_ready_a = 1'b1;
    start_b = 1'b0; sel_b = 1'b0; out_ready_b = 1'b1;
    load_en = 1'b0; load_addr = '0; load_val = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, with start held high during reset
    check("rst_busy", busy_a, 0);
    check("rst_rd_en", rd_en_a, 0);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_peak_valid", peak_valid_a, 0);
    check("rst_done", done_a, 0);
    check("rst_out_data", out_data_a, 0);
    start_a = 1'b0; res = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", busy_a, 0);

    // 1: basic scan, ready high
    load_ram(s1w);
    base = bd_a.size(); pbase = pk_cnt_a.size(); cbase = clr_cnt_a;
    scan_a(1'b1, 0, dcyc);
    check("s1_done_cycle", dcyc, 27);
    check_beats_a("s1", base, s1w);
    check_peaks_a("s1", pbase, 1, 7, 0, 0, 1'b1);
    check("s1_clr_count", clr_cnt_a - cbase, 8);

    // 2: ready toggling 1,0,0,1
    load_ram(s1w);
    base = bd_a.size(); pbase = pk_cnt_a.size(); cbase = clr_cnt_a;
    scan_a(1'b0, 1, dcyc);
    check_beats_a("s2", base, s1w);
    check_peaks_a("s2", pbase, 1, 7, 0, 0, 1'b0);
    check("s2_stable", unstable_a, 0);
    check("s2_clr_count", clr_cnt_a - cbase, 8);
    for (int i = 0; i < WORDS; i++) check($sformatf("s2_ram%0d", i), ram_a[i], 0);

    // 3: equal maxima at both ends keep bin 0
    load_ram(s3w);
    base = bd_a.size(); pbase = pk_cnt_a.size();
    scan_a(1'b1, 0, dcyc);
    check_beats_a("s3", base, s3w);
    check_peaks_a("s3", pbase, 0, 255, 0, 0, 1'b1);

    // 4: start while busy is ignored
    load_ram(s4w);
    base = bd_a.size(); pbase = pk_cnt_a.size(); dbase = done_cnt_a;
    scan_a(1'b0, 2, dcyc);
    repeat (20) @(posedge clk);
    #1;
    check_beats_a("s4", base, s4w);
    check_peaks_a("s4", pbase, 3, 4, 0, 4, 1'b0);
    check("s4_done_count", done_cnt_a - dbase, 1);
    check("s4_idle_after", busy_a, 0);

    // 5: reset during the third beat's SEND
    load_ram(s5w);
    sel_a = 1'b1; start_a = 1'b1; out_ready_a = 1'b0;
    @(posedge clk); #1;
    start_a = 1'b0;
    idx = 0; n = 0;
    while (n < 200) begin
      if (out_valid_a === 1'b1) begin
        if (idx < 2) begin
          out_ready_a = 1'b1;
          @(posedge clk); #1;
          out_ready_a = 1'b0;
          idx++;
        end else begin
          break;
        end
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    check("s5_reached_beat3", out_valid_a, 1);
    res = 1'b0;
    #1;
    check("s5_busy", busy_a, 0);
    check("s5_rd_en", rd_en_a, 0);
    check("s5_rd_addr", rd_addr_a, 0);
    check("s5_clr_en", clr_en_a, 0);
    check("s5_clr_addr", clr_addr_a, 0);
    check("s5_out_valid", out_valid_a, 0);
    check("s5_out_data", out_data_a, 0);
    check("s5_out_bin", out_bin_a, 0);
    check("s5_out_last", out_last_a, 0);
    check("s5_peak_valid", peak_valid_a, 0);
    check("s5_peak_count", peak_count_a, 0);
    check("s5_peak_sel", peak_sel_a, 0);
    check("s5_done", done_a, 0);
    out_ready_a = 1'b1;
    rsnap = rd_cnt_a; csnap = clr_cnt_a;
    repeat (3) @(posedge clk);
    #1 res = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("s5_no_rd", rd_cnt_a - rsnap, 0);
    check("s5_no_clr", clr_cnt_a - csnap, 0);
    check("s5_ram0", ram_a[0], 0);
    check("s5_ram1", ram_a[1], 0);
    for (int i = 2; i < WORDS; i++) check($sformatf("s5_ram%0d", i), ram_a[i], s5w[i*8 +: 8]);
    pbase = pk_cnt_a.size();
    sel_a = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("s5_restart_rd_en", rd_en_a, 1);
    check("s5_restart_addr", rd_addr_a, 0);
    n = 0;
    while (done_a !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("s5_restart_done", done_a, 1);
    @(posedge clk); #1;
    check_peaks_a("s5", pbase, 2, 7, 3, 9, 1'b1);

    // 6: read-only instance
    load_ram(s1w);
    sel_b = 1'b1; start_b = 1'b1; out_ready_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0;
    while (done_b !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("s6_done", done_b, 1);
    check("s6_done_cycle", n + 1, 27);
    @(posedge clk); #1;
    check("s6_beats", bd_b.size(), 8);
    if (bd_b.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("s6_data%0d", i), bd_b[i], s1w[i*8 +: 8]);
        check($sformatf("s6_last%0d", i), bl_b[i], (i == 7) ? 1 : 0);
      end
    end
    check("s6_peaks", pk_cnt_b.size(), 2);
    if (pk_cnt_b.size() == 2) check("s6_p0cnt", pk_cnt_b[0], 7);
    check("s6_clr_count", clr_cnt_b, 0);
    check("s6_done_count", done_cnt_b, 1);
    check("s6_idle", busy_b, 0);
    for (int i = 0; i < WORDS; i++) check($sformatf("s6_ram%0d", i), ram_b[i], s1w[i*8 +: 8]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
